silife_grid_reader: RTL

//   Read-out end of the cell array: takes a flat snapshot of every cell's state output and

---
 rtl/silife_pkg.sv | 16 +
 rtl/silife_grid_reader_if.sv | 21 ++
 rtl/silife_row_popcount.sv | 17 +
 rtl/silife_grid_reader.sv | 99 +++++++++
 4 files changed

// File: rtl/silife_pkg.sv
// Shared types and geometry for the cell-grid read-out path.
package silife_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH  = 8;
  localparam int HEIGHT = 8;
  localparam int ROW_W  = $clog2(HEIGHT);
  localparam int POP_W  = $clog2(WIDTH * HEIGHT + 1);
  localparam int CNT_W  = $clog2(WIDTH + 1);

endpackage

// File: rtl/silife_grid_reader_if.sv
// Row-stream valid/ready channel carrying one snapshot row per beat.
interface silife_grid_reader_if;
  import silife_pkg::*;

  logic [WIDTH-1:0] out_data;
  logic [ROW_W-1:0] out_row;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport master (
    output out_data, out_row, out_valid, out_last,
    input  out_ready
  );

  modport slave (
    input  out_data, out_row, out_valid, out_last,
    output out_ready
  );

endinterface

// File: rtl/silife_row_popcount.sv
// Counts live cells in one row; purely combinational.
module silife_row_popcount
  import silife_pkg::*;
(
  input  logic [WIDTH-1:0] row,
  output logic [CNT_W-1:0] count
);

  always_comb begin
    // NOTE: assigning a default before the loop keeps this block free of inferred latches.
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CNT_W'(row[i]);
    end
  end

endmodule

// File: rtl/silife_grid_reader.sv
// Snapshots the whole cell grid in one cycle and streams it row by row,
// accumulating the live-cell population of the frame.
module silife_grid_reader
  import silife_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [WIDTH*HEIGHT-1:0]   cells,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic [POP_W-1:0]          population,
  output logic                      done,
  silife_grid_reader_if.master      stream
);

  state_t                       state;
  state_t                       state_nxt;
  logic [HEIGHT-1:0][WIDTH-1:0] snapshot;
  logic [ROW_W-1:0]             row;
  logic [POP_W-1:0]             acc;
  logic [CNT_W-1:0]             row_count;
  logic                         beat;
  logic                         last_row;

  assign last_row = (row == ROW_W'(HEIGHT - 1));
  assign beat     = stream.out_valid && stream.out_ready;

  silife_row_popcount u_popcount (
    .row   (stream.out_data),
    .count (row_count)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // abort outranks a same-cycle final beat, so an aborted frame never reaches DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEND;
      SEND: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (beat && last_row) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy             = (state == SEND);
    done             = (state == DONE);
    stream.out_valid = (state == SEND);
    stream.out_last  = (state == SEND) && last_row;
    stream.out_row   = row;
    stream.out_data  = snapshot[row];
  end

  // NOTE: the snapshot register is reset too, so out_data reads zero after reset rather than stale cells.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snapshot   <= '0;
      row        <= '0;
      acc        <= '0;
      population <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snapshot <= cells;
            row      <= '0;
            acc      <= '0;
          end
        end
        SEND: begin
          if (!abort && beat) begin
            acc <= acc + POP_W'(row_count);
            if (!last_row) begin
              row <= row + 1'b1;
            end
          end
        end
        DONE:    population <= acc;
        default: ;
      endcase
    end
  end

endmodule
